// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt controller.
package intr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_HANDLER  = 2'd2
    } intr_state_e;

    localparam logic [31:0] VEC_BASE_DEFAULT   = 32'h0000_0100;
    localparam int unsigned VEC_STRIDE_DEFAULT = 16;

    // Width of an interrupt index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: multi-flop synchroniser followed by a rising-edge detector.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
            prev_q <= sync_out;
        end
    end

    // prev clears on reset, so a line already high at release reports an edge.
    assign rise_o = sync_out & ~prev_q;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: latches line edges as pending, picks the lowest eligible
// index and issues a one-shot redirect to fetch, then waits for mret.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int          NUM_IRQ     = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] VEC_BASE    = VEC_BASE_DEFAULT,
    parameter int unsigned VEC_STRIDE  = VEC_STRIDE_DEFAULT,
    localparam int         ID_W        = id_width(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               global_en,
    input  logic               stall,
    input  logic [31:0]        pc_resume,
    input  logic               mret,
    output logic               interrupt_en,
    output logic [31:0]        interrupt_handling_addr,
    output logic [31:0]        epc,
    output logic               in_handler,
    output logic [ID_W-1:0]    active_id,
    output logic [NUM_IRQ-1:0] pending,
    output intr_state_e        state_o
);

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clr;
    logic               sel_valid;
    logic [ID_W-1:0]    sel_id;

    intr_state_e        state_q, state_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [ID_W-1:0]    active_id_q, active_id_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        epc_q, epc_d;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .rst   (rst),
            .irq_i (irq_in[g]),
            .rise_o(rise[g])
        );
    end

    assign eligible = pending_q & irq_mask;

    // Scanning downward leaves the lowest set index as the winner.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_valid = 1'b1;
                sel_id    = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        active_id_d = active_id_q;
        addr_d      = addr_q;
        epc_d       = epc_q;
        clr         = '0;
        case (state_q)
            ST_IDLE: begin
                if (global_en && sel_valid) begin
                    state_d     = ST_REDIRECT;
                    active_id_d = sel_id;
                    addr_d      = VEC_BASE + (32'(sel_id) * VEC_STRIDE);
                    clr         = NUM_IRQ'(1) << sel_id;
                end
            end
            ST_REDIRECT: begin
                if (!stall) begin
                    epc_d   = pc_resume;
                    state_d = ST_HANDLER;
                end
            end
            ST_HANDLER: begin
                if (mret) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A new edge on the bit being taken keeps it pending.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            active_id_q <= '0;
            addr_q      <= '0;
            epc_q       <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            active_id_q <= active_id_d;
            addr_q      <= addr_d;
            epc_q       <= epc_d;
        end
    end

    assign interrupt_en            = (state_q == ST_REDIRECT);
    assign in_handler              = (state_q == ST_HANDLER);
    assign interrupt_handling_addr = addr_q;
    assign epc                     = epc_q;
    assign active_id               = active_id_q;
    assign pending                 = pending_q;
    assign state_o                 = state_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: cycle table, directed corner sequences and a randomized
// run against a rule-level reference model.
module tb_intr_ctrl;
    import intr_pkg::*;

    localparam int          N      = 4;
    localparam int          S      = 2;
    localparam logic [31:0] BASE   = 32'h0000_0100;
    localparam int          STRIDE = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [N-1:0] irq_in, irq_mask;
    logic        global_en, stall, mret;
    logic [31:0] pc_resume;
    logic        interrupt_en, in_handler;
    logic [31:0] interrupt_handling_addr, epc;
    logic [1:0]  active_id;
    logic [N-1:0] pending;
    intr_state_e state_o;

    int tests  = 0;
    int failed = 0;

    intr_ctrl #(
        .NUM_IRQ(N), .SYNC_STAGES(S), .VEC_BASE(BASE), .VEC_STRIDE(STRIDE)
    ) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .irq_mask(irq_mask),
        .global_en(global_en), .stall(stall), .pc_resume(pc_resume), .mret(mret),
        .interrupt_en(interrupt_en), .interrupt_handling_addr(interrupt_handling_addr),
        .epc(epc), .in_handler(in_handler), .active_id(active_id),
        .pending(pending), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  irq;
        logic [3:0]  mask;
        logic        stall;
        logic        mret;
        logic [31:0] pc;
        logic        exp_en;
        logic [31:0] exp_addr;
        logic        exp_inh;
        logic [3:0]  exp_pend;
        logic [31:0] exp_epc;
        logic [1:0]  exp_id;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(logic [3:0] irq, logic [3:0] mask, logic st, logic mr,
                                logic [31:0] pc, logic en, logic [31:0] addr, logic inh,
                                logic [3:0] pend, logic [31:0] e, logic [1:0] id);
        vec_t v;
        v.irq = irq; v.mask = mask; v.stall = st; v.mret = mr; v.pc = pc;
        v.exp_en = en; v.exp_addr = addr; v.exp_inh = inh; v.exp_pend = pend;
        v.exp_epc = e; v.exp_id = id;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; irq_in = '0; irq_mask = '0; global_en = 1'b0;
        stall = 1'b0; mret = 1'b0; pc_resume = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_en(input int budget);
        int n = 0;
        while (!interrupt_en && n < budget) begin
            step();
            n++;
        end
        chk("wait_en", 32'(interrupt_en), 32'd1);
    endtask

    // Reference model: per-edge rules stated on pending bits and take/return events.
    logic [N-1:0] samp[$];
    logic [N-1:0] m_pend;
    bit           m_redir, m_hand;
    logic [31:0]  m_addr, m_epc;
    logic [1:0]   m_id;

    task automatic model_reset();
        samp.delete();
        for (int i = 0; i <= S; i++) samp.push_back('0);
        m_pend = '0; m_redir = 0; m_hand = 0; m_addr = '0; m_epc = '0; m_id = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] rise;
        int e, low;
        rise = samp[S-1] & ~samp[S];
        samp.push_front(irq_in);
        void'(samp.pop_back());
        if (m_redir) begin
            if (!stall) begin
                m_epc = pc_resume; m_redir = 0; m_hand = 1;
            end
        end else if (m_hand) begin
            if (mret) m_hand = 0;
        end else if (global_en && (m_pend & irq_mask) != 0) begin
            e      = int'(m_pend & irq_mask);
            low    = e & -e;
            m_id   = 2'($clog2(low));
            m_addr = BASE + 32'(m_id) * STRIDE;
            m_pend = m_pend & ~N'(low);
            m_redir = 1;
        end
        m_pend = m_pend | rise;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_en", 32'(interrupt_en), 0);
        chk("rst_inh", 32'(in_handler), 0);
        chk("rst_pend", 32'(pending), 0);
        chk("rst_epc", epc, 0);
        chk("rst_addr", interrupt_handling_addr, 0);
        chk("rst_id", 32'(active_id), 0);
        chk("rst_state", 32'(state_o), 32'(ST_IDLE));

        // Basic take, then priority/masking with a later unmask
        tbl[0]  = mk(4'b0100, 4'b1111, 0, 0, 32'h0,  0, 32'h0,   0, 4'b0000, 32'h0,  2'd0);
        tbl[1]  = mk(4'b0100, 4'b1111, 0, 0, 32'h0,  0, 32'h0,   0, 4'b0000, 32'h0,  2'd0);
        tbl[2]  = mk(4'b0100, 4'b1111, 0, 0, 32'h0,  0, 32'h0,   0, 4'b0100, 32'h0,  2'd0);
        tbl[3]  = mk(4'b0100, 4'b1111, 0, 0, 32'h0,  1, 32'h120, 0, 4'b0000, 32'h0,  2'd2);
        tbl[4]  = mk(4'b0100, 4'b1111, 0, 0, 32'h40, 0, 32'h120, 1, 4'b0000, 32'h40, 2'd2);
        tbl[5]  = mk(4'b0000, 4'b1111, 0, 0, 32'h0,  0, 32'h120, 1, 4'b0000, 32'h40, 2'd2);
        tbl[6]  = mk(4'b0000, 4'b1111, 0, 1, 32'h0,  0, 32'h120, 0, 4'b0000, 32'h40, 2'd2);
        tbl[7]  = mk(4'b1010, 4'b1101, 0, 0, 32'h0,  0, 32'h120, 0, 4'b0000, 32'h40, 2'd2);
        tbl[8]  = mk(4'b1010, 4'b1101, 0, 0, 32'h0,  0, 32'h120, 0, 4'b0000, 32'h40, 2'd2);
        tbl[9]  = mk(4'b1010, 4'b1101, 0, 0, 32'h0,  0, 32'h120, 0, 4'b1010, 32'h40, 2'd2);
        tbl[10] = mk(4'b1010, 4'b1101, 0, 0, 32'h0,  1, 32'h130, 0, 4'b0010, 32'h40, 2'd3);
        tbl[11] = mk(4'b1010, 4'b1101, 0, 0, 32'h80, 0, 32'h130, 1, 4'b0010, 32'h80, 2'd3);
        tbl[12] = mk(4'b1010, 4'b1101, 0, 1, 32'h0,  0, 32'h130, 0, 4'b0010, 32'h80, 2'd3);
        tbl[13] = mk(4'b1010, 4'b1101, 0, 0, 32'h0,  0, 32'h130, 0, 4'b0010, 32'h80, 2'd3);
        tbl[14] = mk(4'b1010, 4'b1111, 0, 0, 32'h0,  1, 32'h110, 0, 4'b0000, 32'h80, 2'd1);
        tbl[15] = mk(4'b1010, 4'b1111, 0, 0, 32'hC0, 0, 32'h110, 1, 4'b0000, 32'hC0, 2'd1);
        tbl[16] = mk(4'b1010, 4'b1111, 0, 1, 32'h0,  0, 32'h110, 0, 4'b0000, 32'hC0, 2'd1);
        tbl[17] = mk(4'b0000, 4'b1111, 0, 0, 32'h0,  0, 32'h110, 0, 4'b0000, 32'hC0, 2'd1);

        global_en = 1'b1; irq_mask = 4'b1111;
        step();
        step();
        for (int r = 0; r < 18; r++) begin
            irq_in = tbl[r].irq; irq_mask = tbl[r].mask; stall = tbl[r].stall;
            mret = tbl[r].mret; pc_resume = tbl[r].pc;
            step();
            chk($sformatf("tbl%0d_en", r),   32'(interrupt_en), 32'(tbl[r].exp_en));
            chk($sformatf("tbl%0d_addr", r), interrupt_handling_addr, tbl[r].exp_addr);
            chk($sformatf("tbl%0d_inh", r),  32'(in_handler), 32'(tbl[r].exp_inh));
            chk($sformatf("tbl%0d_pend", r), 32'(pending), 32'(tbl[r].exp_pend));
            chk($sformatf("tbl%0d_epc", r),  epc, tbl[r].exp_epc);
            chk($sformatf("tbl%0d_id", r),   32'(active_id), 32'(tbl[r].exp_id));
        end
        mret = 1'b0;

        // Stall hold during REDIRECT
        do_reset();
        global_en = 1'b1; irq_mask = 4'b1111; irq_in = 4'b0001;
        wait_en(10);
        chk("stall_addr0", interrupt_handling_addr, 32'h100);
        for (int k = 0; k < 5; k++) begin
            stall = 1'b1; pc_resume = $urandom;
            step();
            chk("stall_en", 32'(interrupt_en), 1);
            chk("stall_addr", interrupt_handling_addr, 32'h100);
            chk("stall_inh", 32'(in_handler), 0);
        end
        stall = 1'b0; pc_resume = 32'hABC0;
        step();
        chk("stall_epc", epc, 32'hABC0);
        chk("stall_inh1", 32'(in_handler), 1);
        chk("stall_en0", 32'(interrupt_en), 0);

        // No nesting: a new edge in HANDLER waits for mret
        irq_in = 4'b0000;
        step();
        irq_in = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("nest_en", 32'(interrupt_en), 0);
        end
        chk("nest_pend", 32'(pending), 32'b0001);
        mret = 1'b1;
        step();
        mret = 1'b0;
        chk("nest_idle_en", 32'(interrupt_en), 0);
        chk("nest_idle_inh", 32'(in_handler), 0);
        chk("nest_idle_state", 32'(state_o), 32'(ST_IDLE));
        step();
        chk("nest_take_en", 32'(interrupt_en), 1);
        chk("nest_take_addr", interrupt_handling_addr, 32'h100);
        chk("nest_take_pend", 32'(pending), 0);

        // Set/clear collision on line 2
        do_reset();
        global_en = 1'b1; irq_mask = 4'b0000; irq_in = 4'b0100;
        step();
        step();
        irq_in = 4'b0000;
        repeat (4) step();
        chk("col_pend0", 32'(pending), 32'b0100);
        chk("col_en0", 32'(interrupt_en), 0);
        irq_in = 4'b0100;
        step();
        step();
        irq_mask = 4'b1111;
        step();
        chk("col_en", 32'(interrupt_en), 1);
        chk("col_addr", interrupt_handling_addr, 32'h120);
        chk("col_pend", 32'(pending), 32'b0100);
        pc_resume = 32'h2000;
        step();
        chk("col_epc", epc, 32'h2000);
        mret = 1'b1;
        step();
        mret = 1'b0;
        step();
        chk("col_retake_en", 32'(interrupt_en), 1);
        chk("col_retake_addr", interrupt_handling_addr, 32'h120);
        chk("col_retake_pend", 32'(pending), 0);

        // Reset while in REDIRECT, line 2 held high throughout
        rst = 1'b1;
        #2;
        chk("mid_rst_en", 32'(interrupt_en), 0);
        chk("mid_rst_pend", 32'(pending), 0);
        chk("mid_rst_epc", epc, 0);
        chk("mid_rst_state", 32'(state_o), 32'(ST_IDLE));
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k < 3) chk($sformatf("rel_e%0d_en", k), 32'(interrupt_en), 0);
            if (k == 2) chk("rel_e2_pend", 32'(pending), 32'b0100);
            if (k == 3) begin
                chk("rel_e3_en", 32'(interrupt_en), 1);
                chk("rel_e3_addr", interrupt_handling_addr, 32'h120);
            end
        end

        // Randomized run against the reference model
        do_reset();
        model_reset();
        irq_mask = 4'b1111;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) irq_in[b] = ~irq_in[b];
            if ($urandom_range(15) == 0) irq_mask = 4'($urandom);
            global_en = ($urandom_range(9) != 0);
            stall     = ($urandom_range(2) == 0);
            mret      = ($urandom_range(3) == 0);
            pc_resume = $urandom;
            step();
            model_step();
            chk("rnd_en",   32'(interrupt_en), 32'(m_redir));
            chk("rnd_inh",  32'(in_handler), 32'(m_hand));
            chk("rnd_addr", interrupt_handling_addr, m_addr);
            chk("rnd_epc",  epc, m_epc);
            chk("rnd_id",   32'(active_id), 32'(m_id));
            chk("rnd_pend", 32'(pending), 32'(m_pend));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt controller on the responder side of the fetch stage's redirect interface.
- Synchronises external interrupt lines, latches edges as pending requests and selects one by fixed priority.
- Drives a one-shot redirect (interrupt_en plus handler address) that fetch honours on a non-stalled edge, and saves the resume PC.
- Tracks the handler until mret. No nesting.

Parameters:
NUM_IRQ, 4, number of external interrupt lines (1..16)
SYNC_STAGES, 2, synchroniser flops per line (>=2)
VEC_BASE, 32'h0000_0100, byte address of vector 0
VEC_STRIDE, 16, byte spacing between vectors

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
irq_in  in  NUM_IRQ  asynchronous interrupt lines, rising-edge triggered
irq_mask  in  NUM_IRQ  per-line enable, 1 = may be taken
global_en  in  1  global interrupt enable
stall  in  1  fetch stall; the PC register does not update while high
pc_resume  in  32  fetch's pcPlus4, the resume address if redirected this cycle
mret  in  1  one-cycle pulse: handler return retired
interrupt_en  out  1  redirect request to fetch
interrupt_handling_addr  out  32  handler vector, valid while interrupt_en=1
epc  out  32  saved resume PC
in_handler  out  1  high while a handler runs
active_id  out  ID_W  index of the taken interrupt (ID_W = max(1, clog2(NUM_IRQ)))
pending  out  NUM_IRQ  pending request bits, including masked ones

Behaviour:
- Reset: synchroniser chains, edge-history flops and pending are cleared. All outputs are 0. FSM enters IDLE.
- Edge detection: rise[i] = sync_out[i] & ~prev[i]; prev <= sync_out. A line already high at reset release counts as a rising edge.
- Latency with SYNC_STAGES=2 (edge 0 = first edge sampling irq_in=1): pending visible after edge 2; IDLE->REDIRECT at edge 3; fetch loads the vector at edge 4 when stall=0.
- pending[i] is set by rise[i] and cleared only when i is taken. If set and clear coincide on the same bit, set wins and the bit stays pending.
- Masked pending bits are retained and become eligible when unmasked.
- Eligible vector = pending & irq_mask. Priority: lowest index wins.
- FSM IDLE:
  - On global_en=1 and an eligible bit: go to REDIRECT.
  - Latch active_id and interrupt_handling_addr = VEC_BASE + active_id*VEC_STRIDE, computed as 32-bit unsigned.
  - Clear the chosen pending bit.
  - mret is ignored in IDLE.
- FSM REDIRECT:
  - interrupt_en=1, registered and driven from state.
  - If stall=1: hold interrupt_en=1 with address unchanged and stay in REDIRECT.
  - If stall=0: on the edge, epc <= pc_resume and go to HANDLER.
  - Deasserting global_en or changing irq_mask in REDIRECT does not cancel the redirect.
- FSM HANDLER:
  - in_handler=1 and interrupt_en=0. New edges still accumulate in pending; no further redirect is issued.
  - On mret=1: go to IDLE. in_handler drops after that edge.
  - The earliest next redirect is IDLE->REDIRECT on the following edge, so there is at least one IDLE cycle.
- epc and active_id hold their values until the next take.
- interrupt_handling_addr holds its last value outside REDIRECT.
- Reset asserted in any state returns everything to reset values immediately. Any in-flight redirect is dropped.

Decomposition:
- Shared package intr_pkg holds:
  - FSM state enum (IDLE, REDIRECT, HANDLER)
  - ID_W function
  - default VEC_BASE and VEC_STRIDE constants
- One sub-module: irq_sync_edge. It holds the per-line SYNC_STAGES synchroniser plus edge-history flop and outputs a one-cycle rise pulse. It is instantiated NUM_IRQ times via generate.
- Priority select and vector arithmetic stay in intr_ctrl.

Test Plan:
- Basic take:
  - Stimulus: global_en=1, mask=4'b1111, irq_in[2] rises, stall=0, pc_resume=32'h40.
  - Required: interrupt_en high exactly one cycle, after edge 3; address 32'h120; epc=32'h40; active_id=2; in_handler=1 after edge 4.
- Priority and masking:
  - Stimulus: irq_in[1] and irq_in[3] rise together with mask=4'b1101.
  - Required: line 3 taken (addr 32'h130); pending=4'b0010 held; after mret and setting mask bit 1, line 1 taken at 32'h110.
- Stall hold:
  - Stimulus: stall=1 for 5 cycles during REDIRECT, with pc_resume changing each cycle.
  - Required: interrupt_en stays 1 with a constant address; epc equals pc_resume from the first cycle with stall=0.
- No nesting / re-pend:
  - Stimulus: irq_in[0] rises while in HANDLER.
  - Required: no redirect until mret; then exactly one IDLE cycle, then a redirect to 32'h100.
- Set/clear collision:
  - Stimulus: the edge for line 2 arrives on the same edge that line 2 is taken.
  - Required: pending[2]=1 afterwards; line 2 is taken again after mret.
- Reset mid-operation:
  - Stimulus: rst pulsed during REDIRECT.
  - Required: interrupt_en=0, pending=0, epc=0, state IDLE. A line held high through reset is taken after SYNC_STAGES+1 edges following release.
